// File: rtl/clk_phase.sv
// Quadrature clock generator: four clk/2 square waves at 0/90/180/270 degrees.
// p0 toggles on rising clk; p90 follows p0 on falling clk, so it always lags by half a clk period.
module clk_phase (
   input  logic clk,
   input  logic rst,
   output logic clk_0,
   output logic clk_90,
   output logic clk_180,
   output logic clk_270
);

   logic p0_q;
   logic p0_d;
   logic p90_q;

   always_comb begin
      p0_d = ~p0_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_q <= 1'b0;
      end else begin
         p0_q <= p0_d;
      end
   end

   // Sampling p0 (rather than toggling independently) keeps the 90-degree order self-aligning.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         p90_q <= 1'b0;
      end else begin
         p90_q <= p0_q;
      end
   end

   assign clk_0   = p0_q;
   assign clk_90  = p90_q;
   assign clk_180 = ~p0_q;
   assign clk_270 = ~p90_q;

endmodule

// File: tb/tb_clk_phase.sv
// Bench for clk_phase: fixed vector table, hand-written reset sequences, edge timing monitor,
// and randomized reset assert/release checked against a time-arithmetic reference model.
`timescale 1ns / 10ps
module tb_clk_phase;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clk_0;
   logic clk_90;
   logic clk_180;
   logic clk_270;

   int errors = 0;
   int checks = 0;

   // Model state: bench's own view of reset and the time (in quarter-ns) of the last release.
   bit rst_m = 1'b1;
   int rel_t4 = 0;

   bit      meas_en = 1'b0;
   realtime last_r0 = 0.0;
   int      n_rises = 0;

   typedef struct {
      realtime    t;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[8];

   clk_phase dut (
      .clk    (clk),
      .rst    (rst),
      .clk_0  (clk_0),
      .clk_90 (clk_90),
      .clk_180(clk_180),
      .clk_270(clk_270)
   );

   // Rising edges at 2, 6, 10, ... ns.
   always #2 clk = ~clk;

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {clk_0, clk_90, clk_180, clk_270};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got {0,90,180,270}=%b want %b", name, $realtime, act, exp);
      end
   endtask

   task automatic check_real(input string name, input realtime act, input realtime exp);
      checks++;
      if (act - exp > 0.001 || exp - act > 0.001) begin
         errors++;
         $display("FAIL %s at %0t: got %0.3f ns want %0.3f ns", name, $realtime, act, exp);
      end
   endtask

   // Outputs from first principles: after release, the first rising clk edge starts clk_0 high
   // for 4 ns / low for 4 ns; clk_90 is the same waveform delayed by 2 ns.
   function automatic logic [3:0] model(input int t4);
      int   t1;
      logic c0;
      logic c90;
      if (rst_m) return 4'b0011;
      t1 = 8;
      while (t1 <= rel_t4) t1 += 16;
      c0  = (t4 >= t1) && (((t4 - t1) / 16) % 2 == 0);
      c90 = (t4 >= t1 + 8) && (((t4 - t1 - 8) / 16) % 2 == 0);
      return {c0, c90, ~c0, ~c90};
   endfunction

   task automatic go_to(input realtime at);
      if (at > $realtime) #(at - $realtime);
   endtask

   task automatic set_rst(input realtime at, input bit v);
      go_to(at);
      rst   = v;
      rst_m = v;
      if (!v) rel_t4 = int'(at * 4.0);
   endtask

   task automatic sample_model(input realtime at, input string name);
      go_to(at);
      check(name, model(int'($realtime * 4.0)));
   endtask

   always @(posedge clk_0) begin
      if (meas_en) begin
         if (last_r0 > 0.0) check_real("clk_0 period", $realtime - last_r0, 8.0);
         last_r0 = $realtime;
         n_rises++;
      end
   end

   always @(negedge clk_0) begin
      if (meas_en && last_r0 > 0.0) check_real("clk_0 high time", $realtime - last_r0, 4.0);
   end

   always @(posedge clk_90) begin
      if (meas_en && last_r0 > 0.0) check_real("clk_90 lag", $realtime - last_r0, 2.0);
   end

   initial begin
      realtime t;
      int      len;

      tbl[0] = '{1.25,  4'b0011};
      tbl[1] = '{4.25,  4'b0011};
      tbl[2] = '{6.25,  4'b1001};
      tbl[3] = '{8.25,  4'b1100};
      tbl[4] = '{10.25, 4'b0110};
      tbl[5] = '{12.25, 4'b0011};
      tbl[6] = '{14.25, 4'b1001};
      tbl[7] = '{16.25, 4'b1100};

      // Release at 5 ns (clk low), then walk the vector table.
      for (int i = 0; i < 8; i++) begin
         if (i == 2) set_rst(5.0, 1'b0);
         go_to(tbl[i].t);
         check($sformatf("table[%0d]", i), tbl[i].exp);
      end

      // Mid-run reset at 23 ns while clk_0=1; no clk edge between 22 and 24 ns.
      go_to(22.75);
      check("before reset 23", 4'b1001);
      set_rst(23.0, 1'b1);
      #0.25;
      check("async reset 23", 4'b0011);

      // Release while clk low; measure edge timing for 55 ns.
      set_rst(25.0, 1'b0);
      meas_en = 1'b1;
      last_r0 = 0.0;
      n_rises = 0;
      go_to(25.75);
      check("release lo 25.75", 4'b0011);
      go_to(26.25);
      check("release lo 26.25", 4'b1001);
      go_to(28.25);
      check("release lo 28.25", 4'b1100);
      go_to(80.0);
      meas_en = 1'b0;
      checks++;
      if (n_rises < 6) begin
         errors++;
         $display("FAIL clk_0 rise count: got %0d want >= 6", n_rises);
      end

      // Reset, then release while clk high (83 ns): still 0 leads 90 by half a clk.
      set_rst(81.0, 1'b1);
      #0.25;
      check("async reset 81", 4'b0011);
      set_rst(83.0, 1'b0);
      go_to(85.25);
      check("release hi 85.25", 4'b0011);
      go_to(86.25);
      check("release hi 86.25", 4'b1001);
      go_to(88.25);
      check("release hi 88.25", 4'b1100);
      go_to(90.25);
      check("release hi 90.25", 4'b0110);

      // Randomized reset pulses at odd-ns instants, sampled every 0.5 ns against the model.
      t = 93.0;
      for (int it = 0; it < 40; it++) begin
         set_rst(t, 1'b1);
         sample_model(t + 0.25, "rand in reset");
         t = t + 2.0 * real'($urandom_range(1, 3));
         set_rst(t, 1'b0);
         len = 2 * int'($urandom_range(1, 15));
         for (int k = 0; k < len; k++) begin
            sample_model(t + 0.25 + 0.5 * real'(k), "rand run");
         end
         t = t + real'(len / 2) + 2.0 * real'($urandom_range(0, 4)) + 1.0;
         if (int'(t) % 2 == 0) t = t + 1.0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
